// File: rtl/branch_predictor_table_arbiter_if.sv
// rtl/branch_predictor_table_arbiter_if.sv - lookup/predict/update handshake bundle for the predictor table arbiter
interface branch_predictor_table_arbiter_if #(
  parameter int PC_WIDTH = 16
);
  logic                LookupValid;
  logic [PC_WIDTH-1:0] LookupPC;
  logic                LookupReady;
  logic                PredictValid;
  logic                PredictTaken;
  logic [1:0]          PredictState;
  logic                UpdateValid;
  logic [PC_WIDTH-1:0] UpdatePC;
  logic                UpdateTaken;
  logic                UpdatePredicted;
  logic                UpdateReady;

  // Requester side: front-end lookups and back-end resolve updates.
  modport master (
    output LookupValid, LookupPC, UpdateValid, UpdatePC, UpdateTaken, UpdatePredicted,
    input  LookupReady, PredictValid, PredictTaken, PredictState, UpdateReady
  );

  // Table side.
  modport slave (
    input  LookupValid, LookupPC, UpdateValid, UpdatePC, UpdateTaken, UpdatePredicted,
    output LookupReady, PredictValid, PredictTaken, PredictState, UpdateReady
  );
endinterface

// File: rtl/branch_predictor_table_arbiter.sv
// rtl/branch_predictor_table_arbiter.sv - single-port 2-bit counter table with lookup/update arbitration; stats under BRANCH_PREDICTOR_STATS_EN
module branch_predictor_table_arbiter #(
  parameter int         ENTRIES    = 64,
  parameter int         INDEX_W    = 6,
  parameter int         PC_WIDTH   = 16,
  parameter int         IDX_LSB    = 1,
  parameter logic [1:0] INIT_STATE = 2'b01
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              FlushReq,
  branch_predictor_table_arbiter_if.slave   bus,
  output logic                              ClearBusy,
  output logic [15:0]                       MispredictCount,
  output logic [15:0]                       UpdateCount
);

  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_RUN   = 1'b1;

  logic [0:0]         state;
  logic [INDEX_W-1:0] clr_idx;
  logic               wb_pending;
  logic [INDEX_W-1:0] wb_idx;
  logic [1:0]         wb_data;
  logic               rr_ptr;        // 0: lookup wins next tie, 1: update wins
  logic [1:0]         table_mem [ENTRIES];

  logic [INDEX_W-1:0] lookup_idx;
  logic [INDEX_W-1:0] update_idx;
  logic               run_free;
  logic               both_valid;
  logic               lookup_acc;
  logic               update_acc;
  logic [INDEX_W-1:0] rd_idx;
  logic [1:0]         rd_data;
  logic [1:0]         next_ctr;
  logic               wr_en;
  logic [INDEX_W-1:0] wr_idx;
  logic [1:0]         wr_data;

  // PC bits outside the index window alias silently; UpdatePredicted only feeds stats.
  logic unused_bits;
  assign unused_bits = ^{bus.LookupPC, bus.UpdatePC, bus.UpdatePredicted};

  assign lookup_idx = bus.LookupPC[IDX_LSB +: INDEX_W];
  assign update_idx = bus.UpdatePC[IDX_LSB +: INDEX_W];

  // The port is free only in RUN with no write-back owed and no flush this cycle.
  assign run_free   = (state == ST_RUN) && !wb_pending && !FlushReq;
  assign both_valid = bus.LookupValid && bus.UpdateValid;

  assign bus.LookupReady = run_free && (!bus.UpdateValid || !rr_ptr);
  assign bus.UpdateReady = run_free && (!bus.LookupValid || rr_ptr);
  assign lookup_acc      = bus.LookupValid && bus.LookupReady;
  assign update_acc      = bus.UpdateValid && bus.UpdateReady;

  assign ClearBusy        = (state == ST_CLEAR);
  assign bus.PredictTaken = bus.PredictState[1];

  // Single read port, steered to whichever requester holds the grant.
  assign rd_idx  = update_acc ? update_idx : lookup_idx;
  assign rd_data = table_mem[rd_idx];

  // Modified two-bit transition: taken jumps straight into the taken half.
  always_comb begin
    next_ctr = 2'b00;
    if (bus.UpdateTaken) next_ctr = {1'b1, |rd_data};
    else                 next_ctr = {1'b0, &rd_data};
  end

  // Write port: clear walk or the write-back half of an update; a flush kills the write-back.
  always_comb begin
    wr_en   = 1'b0;
    wr_idx  = wb_idx;
    wr_data = wb_data;
    if (state == ST_CLEAR) begin
      wr_en   = 1'b1;
      wr_idx  = clr_idx;
      wr_data = INIT_STATE;
    end else if (wb_pending && !FlushReq) begin
      wr_en = 1'b1;
    end
  end

  // Counter storage; contents are meaningless until a clear walk finishes.
  always_ff @(posedge clk) begin
    if (wr_en) table_mem[wr_idx] <= wr_data;
  end

  // Sequencing: clear walk, arbitration pointer, write-back slot and prediction register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= ST_CLEAR;
      clr_idx          <= '0;
      wb_pending       <= 1'b0;
      wb_idx           <= '0;
      wb_data          <= 2'b00;
      rr_ptr           <= 1'b0;
      bus.PredictValid <= 1'b0;
      bus.PredictState <= 2'b00;
    end else if (FlushReq) begin
      state            <= ST_CLEAR;
      clr_idx          <= '0;
      wb_pending       <= 1'b0;
      bus.PredictValid <= 1'b0;
    end else begin
      bus.PredictValid <= 1'b0;
      if (state == ST_CLEAR) begin
        clr_idx <= clr_idx + 1'b1;
        if (clr_idx == INDEX_W'(ENTRIES - 1)) state <= ST_RUN;
      end else begin
        wb_pending       <= update_acc;
        bus.PredictValid <= lookup_acc;
        if (update_acc) begin
          wb_idx  <= update_idx;
          wb_data <= next_ctr;
        end
        if (lookup_acc) bus.PredictState <= rd_data;
        if (run_free && both_valid) rr_ptr <= ~rr_ptr;
      end
    end
  end

`ifdef BRANCH_PREDICTOR_STATS_EN
  // Saturating resolve statistics, cleared by reset and flush.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      UpdateCount     <= 16'h0000;
      MispredictCount <= 16'h0000;
    end else if (FlushReq) begin
      UpdateCount     <= 16'h0000;
      MispredictCount <= 16'h0000;
    end else if (update_acc) begin
      if (UpdateCount != 16'hFFFF) UpdateCount <= UpdateCount + 16'h0001;
      if ((bus.UpdatePredicted != bus.UpdateTaken) && (MispredictCount != 16'hFFFF))
        MispredictCount <= MispredictCount + 16'h0001;
    end
  end
`else
  assign UpdateCount     = 16'h0000;
  assign MispredictCount = 16'h0000;
`endif

endmodule

// File: tb/tb_branch_predictor_table_arbiter.sv
// tb/tb_branch_predictor_table_arbiter.sv - self-checking bench for branch_predictor_table_arbiter
module tb_branch_predictor_table_arbiter;

  logic        clk;
  logic        rst;
  logic        FlushReq;
  logic        ClearBusy;
  logic [15:0] MispredictCount;
  logic [15:0] UpdateCount;

  branch_predictor_table_arbiter_if #(.PC_WIDTH(16)) bus ();

  branch_predictor_table_arbiter dut (
    .clk             (clk),
    .rst             (rst),
    .FlushReq        (FlushReq),
    .bus             (bus.slave),
    .ClearBusy       (ClearBusy),
    .MispredictCount (MispredictCount),
    .UpdateCount     (UpdateCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference: counter values per entry and the transition table.
  int model_tbl [64];
  int nxt_taken [4] = '{2, 3, 3, 3};
  int nxt_not   [4] = '{0, 0, 0, 1};

  typedef struct packed {
    logic        is_upd;
    logic [15:0] pc;
    logic        taken;
    logic        pred;
    logic [1:0]  exp;
  } vec_t;
  vec_t vecs [10];

  function automatic int idx_of(input logic [15:0] pc);
    return (int'(pc) >> 1) % 64;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 64; i++) model_tbl[i] = 1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_clear(output int n);
    n = 0;
    while (ClearBusy && n < 200) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic do_lookup(input logic [15:0] pc, input logic [1:0] exp, input string name);
    int w;
    bus.LookupValid = 1'b1;
    bus.LookupPC    = pc;
    bus.UpdateValid = 1'b0;
    w = 0;
    #1;
    while (!bus.LookupReady && w < 10) begin
      @(negedge clk);
      #1;
      w++;
    end
    chk({name, "_ready"}, bus.LookupReady, 1);
    @(negedge clk);
    bus.LookupValid = 1'b0;
    chk({name, "_pvalid"}, bus.PredictValid, 1);
    chk({name, "_state"}, bus.PredictState, exp);
    chk({name, "_taken"}, bus.PredictTaken, exp[1]);
  endtask

  task automatic do_update(input logic [15:0] pc, input logic taken, input logic pred);
    int w;
    int ix;
    bus.UpdateValid     = 1'b1;
    bus.UpdatePC        = pc;
    bus.UpdateTaken     = taken;
    bus.UpdatePredicted = pred;
    bus.LookupValid     = 1'b0;
    w = 0;
    #1;
    while (!bus.UpdateReady && w < 10) begin
      @(negedge clk);
      #1;
      w++;
    end
    chk("update_ready", bus.UpdateReady, 1);
    @(negedge clk);
    bus.UpdateValid = 1'b0;
    bus.LookupValid = 1'b1;
    bus.LookupPC    = 16'h0000;
    #1;
    chk("wb_lookup_ready", bus.LookupReady, 0);
    chk("wb_update_ready", bus.UpdateReady, 0);
    bus.LookupValid = 1'b0;
    ix = idx_of(pc);
    model_tbl[ix] = taken ? nxt_taken[model_tbl[ix]] : nxt_not[model_tbl[ix]];
    @(negedge clk);
  endtask

  task automatic do_flush();
    int n;
    FlushReq = 1'b1;
    @(negedge clk);
    FlushReq = 1'b0;
    wait_clear(n);
    chk("flush_clear_len", n, 64);
    model_clear();
  endtask

  initial begin
    int n;
    int bad;
    int g;
    int prev;
    int nl;
    int nu;
    bit lk;
    logic [15:0] pc;
    logic        tk;

    vecs[0] = '{1'b0, 16'h0004, 1'b0, 1'b0, 2'b01};
    vecs[1] = '{1'b1, 16'h0010, 1'b1, 1'b0, 2'b00};
    vecs[2] = '{1'b1, 16'h0010, 1'b1, 1'b1, 2'b00};
    vecs[3] = '{1'b0, 16'h0010, 1'b0, 1'b0, 2'b11};
    vecs[4] = '{1'b1, 16'h0010, 1'b0, 1'b1, 2'b00};
    vecs[5] = '{1'b0, 16'h0010, 1'b0, 1'b0, 2'b01};
    vecs[6] = '{1'b1, 16'h0010, 1'b0, 1'b0, 2'b00};
    vecs[7] = '{1'b0, 16'h0010, 1'b0, 1'b0, 2'b00};
    vecs[8] = '{1'b1, 16'h0002, 1'b1, 1'b0, 2'b00};
    vecs[9] = '{1'b0, 16'h0082, 1'b0, 1'b0, 2'b11};

    rst                 = 1'b1;
    FlushReq            = 1'b0;
    bus.LookupValid     = 1'b0;
    bus.LookupPC        = 16'h0000;
    bus.UpdateValid     = 1'b0;
    bus.UpdatePC        = 16'h0000;
    bus.UpdateTaken     = 1'b0;
    bus.UpdatePredicted = 1'b0;
    model_clear();

    // Reset state.
    repeat (3) @(negedge clk);
    chk("rst_clearbusy", ClearBusy, 1);
    chk("rst_lookup_ready", bus.LookupReady, 0);
    chk("rst_update_ready", bus.UpdateReady, 0);
    chk("rst_pvalid", bus.PredictValid, 0);
    chk("rst_pstate", bus.PredictState, 0);
    chk("rst_upd_cnt", UpdateCount, 0);
    chk("rst_mis_cnt", MispredictCount, 0);

    // Clear walk after reset: exactly 64 busy cycles with both readies low.
    rst = 1'b0;
    bus.LookupValid = 1'b1;
    bus.UpdateValid = 1'b1;
    n = 0;
    bad = 0;
    #1;
    while (ClearBusy && n < 200) begin
      if (bus.LookupReady || bus.UpdateReady) bad++;
      @(negedge clk);
      #1;
      n++;
    end
    bus.LookupValid = 1'b0;
    bus.UpdateValid = 1'b0;
    chk("clear_len", n, 64);
    chk("clear_ready_low", bad, 0);
    @(negedge clk);

    // Table-driven training and aliasing.
    for (int i = 0; i < 10; i++) begin
      if (vecs[i].is_upd) do_update(vecs[i].pc, vecs[i].taken, vecs[i].pred);
      else                do_lookup(vecs[i].pc, vecs[i].exp, $sformatf("vec%0d", i));
    end

    // Contention: both requesters held high.
    bus.LookupValid = 1'b1;
    bus.LookupPC    = 16'h0010;
    bus.UpdateValid = 1'b1;
    bus.UpdatePC    = 16'h0040;
    prev = -1;
    nl = 0;
    nu = 0;
    for (int i = 0; i < 30; i++) begin
      bus.UpdateTaken = 1'($urandom % 2);
      #1;
      chk("cont_single_grant", {31'd0, bus.LookupReady & bus.UpdateReady}, 0);
      g = bus.LookupReady ? 1 : (bus.UpdateReady ? 2 : 0);
      if (prev == -1)     chk("cont_first_grant", (g != 0), 1);
      else if (prev == 2) chk("cont_wb_slot", g, 0);
      else if (prev == 0) chk("cont_after_wb", g, 1);
      else                chk("cont_after_lookup", g, 2);
      if (g == 2) begin
        model_tbl[32] = bus.UpdateTaken ? nxt_taken[model_tbl[32]] : nxt_not[model_tbl[32]];
        nu++;
      end
      if (g == 1) nl++;
      lk = (g == 1);
      @(negedge clk);
      chk("cont_pvalid", bus.PredictValid, lk);
      if (lk) chk("cont_pstate", bus.PredictState, model_tbl[8]);
      prev = g;
    end
    bus.LookupValid = 1'b0;
    bus.UpdateValid = 1'b0;
    chk("cont_lookups_served", (nl >= 9), 1);
    chk("cont_updates_served", (nu >= 9), 1);
    @(negedge clk);

    // Randomized traffic against the reference table.
    for (int i = 0; i < 40; i++) begin
      pc = 16'($urandom);
      tk = 1'($urandom % 2);
      if ($urandom % 2) do_lookup(pc, 2'(model_tbl[idx_of(pc)]), "rand_lookup");
      else              do_update(pc, tk, 1'($urandom % 2));
    end

    // Flush landing in the write-back cycle of an update to index 5.
    do_flush();
    bus.UpdateValid = 1'b1;
    bus.UpdatePC    = 16'h000A;
    bus.UpdateTaken = 1'b1;
    n = 0;
    #1;
    while (!bus.UpdateReady && n < 10) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("rmw_update_ready", bus.UpdateReady, 1);
    @(negedge clk);
    bus.UpdateValid = 1'b0;
    FlushReq        = 1'b1;
    bus.LookupValid = 1'b1;
    bus.LookupPC    = 16'h000A;
    #1;
    chk("flush_cycle_lookup_ready", bus.LookupReady, 0);
    @(negedge clk);
    FlushReq        = 1'b0;
    bus.LookupValid = 1'b0;
    chk("flush_pvalid", bus.PredictValid, 0);
    chk("flush_clearbusy", ClearBusy, 1);
    wait_clear(n);
    chk("flush_rmw_clear_len", n, 64);
    do_lookup(16'h000A, 2'b01, "flush_idx5");

    // Stats: counts were cleared by the flush above.
    do_update(16'h0020, 1'b1, 1'b1);
    do_update(16'h0020, 1'b1, 1'b0);
    do_update(16'h0020, 1'b0, 1'b1);
`ifdef BRANCH_PREDICTOR_STATS_EN
    chk("stats_update_count", UpdateCount, 3);
    chk("stats_mispredict_count", MispredictCount, 2);
`else
    chk("stats_update_count", UpdateCount, 0);
    chk("stats_mispredict_count", MispredictCount, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/branch_predictor_table_arbiter.md
Name: branch_predictor_table_arbiter

Overview:
- Owns a single-ported table of 2-bit branch-predictor counters.
- Arbitrates the one port between front-end prediction lookups and back-end resolve updates.
- Each update is sequenced as a read-modify-write using the modified two-bit transition function.
- After reset or flush, a clear state machine walks the table to a known state; it sits between fetch (lookup) and branch resolve (update).

Parameters:
- ENTRIES, 64, number of counters; power of two, >= 2.
- INDEX_W, 6, log2(ENTRIES).
- PC_WIDTH, 16, PC width.
- IDX_LSB, 1, lowest PC bit used for the index; index = PC[IDX_LSB+INDEX_W-1:IDX_LSB].
- INIT_STATE, 2'b01, value written by clear (weakly not taken).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- FlushReq  in  1  restart clear sequence
- LookupValid  in  1  lookup request
- LookupPC  in  PC_WIDTH  lookup address
- LookupReady  out  1  lookup accepted this cycle
- PredictValid  out  1  prediction result valid
- PredictTaken  out  1  predicted direction = counter[1]
- PredictState  out  2  raw counter value
- UpdateValid  in  1  resolve update request
- UpdatePC  in  PC_WIDTH  resolved branch address
- UpdateTaken  in  1  actual direction
- UpdatePredicted  in  1  direction that was predicted (stats only)
- UpdateReady  out  1  update accepted this cycle
- ClearBusy  out  1  clear in progress
- MispredictCount  out  16  stats (see Optional Feature)
- UpdateCount  out  16  stats (see Optional Feature)

Behaviour:
- Reset values:
  - Async reset forces state CLEAR, clear index 0, no write-back pending, round-robin pointer = lookup.
  - All outputs 0 except ClearBusy = 1.
- States:
  - CLEAR:
    - Writes INIT_STATE to one entry per cycle, index 0..ENTRIES-1.
    - LookupReady = UpdateReady = 0.
    - After writing entry ENTRIES-1, goes to RUN next cycle; ClearBusy falls the same cycle.
    - Takes exactly ENTRIES cycles.
  - RUN: one port operation per cycle, in this priority:
    1. Pending write-back (WB): always wins; LookupReady = UpdateReady = 0.
    2. If both lookup and update are valid, round-robin. The winner gets Ready = 1 and the pointer flips to the other requester.
    3. If only one is valid, it is served; the pointer is unchanged.
- Lookup timing:
  - Accepted at cycle N (LookupValid & LookupReady): table read at N.
  - PredictValid = 1 at N+1 with PredictState and PredictTaken registered.
  - PredictValid is otherwise 0; latency is always 1 cycle.
- Update timing:
  - Accepted at cycle N: read at N; the index, UpdateTaken and read value are captured.
  - At N+1 the WB slot writes next = f(UpdateTaken, old).
  - Next accept is possible at N+2 at the earliest. No forwarding is needed, because WB blocks the port for the cycle after every update read.
- Transition f:
  - Taken: 00->10, 01->11, 10->11, 11->11.
  - Not taken: 00->00, 01->00, 10->00, 11->01.
- Ready is combinational from state, WB and the round-robin pointer. It is independent of the requester's own Valid, except for the round-robin decision.
- FlushReq (sampled at clk):
  - Drops any pending WB (the write does not happen).
  - Clears PredictValid next cycle and enters CLEAR at index 0.
  - FlushReq asserted during CLEAR restarts at index 0.
  - No request is accepted in the flush cycle.
- Index wrap: PC bits above the index alias silently; no tags.
- Reset mid-operation: the async reset aborts everything immediately. Table contents are undefined until the clear sequence completes.

Optional Feature:
- Macro: BRANCH_PREDICTOR_STATS_EN.
- Defined:
  - UpdateCount increments on every accepted update.
  - MispredictCount increments on an accepted update when UpdatePredicted != UpdateTaken.
  - Both are 16-bit, saturate at 16'hFFFF, and are cleared by rst and FlushReq.
- Undefined: both outputs are tied to 0 and no counter flops exist.

Test Plan:
- Reset release:
  - ClearBusy = 1 for exactly 64 cycles, with Ready = 0 throughout.
  - Then lookup of PC 16'h0004 gives PredictState = 2'b01, PredictTaken = 0 one cycle after accept.
- Training:
  - Two taken updates to PC 16'h0010 (01->11, 11->11), then a lookup gives PredictState = 2'b11, PredictTaken = 1.
  - One not-taken update gives 2'b01.
  - A second not-taken update gives 2'b00.
- Contention:
  - LookupValid and UpdateValid held high continuously from RUN.
  - Grants must follow the port pattern update-read, WB, lookup, update-read, WB, lookup, ...
  - No requester is starved; UpdateReady is never 1 in a WB cycle.
- Aliasing: an update to PC 16'h0002 and a lookup of PC 16'h0082 (same index 1) must observe the same counter.
- Flush mid-RMW:
  - Accept a taken update on index 5 (value 01), then assert FlushReq in the WB cycle.
  - After the new clear completes, index 5 reads 2'b01 and PredictValid was 0 the cycle after the flush.
- Stats (macro defined):
  - 3 updates with UpdatePredicted/UpdateTaken = 1/1, 0/1, 1/0 give UpdateCount = 3 and MispredictCount = 2.
  - With the macro undefined, both read 0.
